ltl_nfa_engine: RTL and testbench

Parametrised, run-time-programmable homogeneous NFA engine for LTL runtime monitoring in the core's RM monitor clusters. It replaces per-property hard-coded STE/LUT automata with an N-state engine whose symbol ranges, edges, start types and report flags are loaded through a configuration port. It consumes one trace symbol per accepted cycle and reports per-state matches. An optional counter/first-report capture supports monitor debug.

---
 rtl/ltl_nfa_engine.sv | 155 +++++++++++++++
 tb/tb_ltl_nfa_engine.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ltl_nfa_engine.sv
// Run-time programmable homogeneous NFA engine for LTL trace monitoring.
// Optional report counter / first-report capture: define LTL_NFA_REPORT_CNT_EN.
module ltl_nfa_engine #(
  parameter int SYM_W   = 8,
  parameter int N_STE   = 16,
  parameter int N_RANGE = 4,
  localparam int IDX_W  = (N_STE > 1) ? $clog2(N_STE) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_ste,
  input  logic [3:0]       cfg_field,
  input  logic [31:0]      cfg_data,
  output logic             cfg_err,
  input  logic             run,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] symbols,
  input  logic             flush,
  output logic [N_STE-1:0] active,
  output logic [N_STE-1:0] report_vec,
  output logic             report,
  output logic [15:0]      report_cnt,
  output logic [4:0]       first_idx,
  output logic             first_vld
);

  logic [SYM_W-1:0] range_lo_r [N_STE][N_RANGE];
  logic [SYM_W-1:0] range_hi_r [N_STE][N_RANGE];
  logic [N_STE-1:0] edge_r [N_STE];
  logic [N_STE-1:0] report_r, start_all_r, start_sod_r;
  logic [N_STE-1:0] active_r;
  logic             sod_r, cfg_err_r;
  logic             cfg_ok_s, cfg_wr_s, accept_s;
  logic [N_STE-1:0] match_s, succ_s, next_active_s;
  logic             unused_cfg_s;

  assign unused_cfg_s = ^cfg_data;

  // Write legality and symbol acceptance qualifiers
  always_comb begin
    cfg_ok_s = (int'(cfg_ste) < N_STE) && (int'(cfg_field) <= N_RANGE + 1);
    cfg_wr_s = cfg_we && !run && cfg_ok_s;
    accept_s = run && sym_valid && !flush;
  end

  // Configuration register file; a dropped write flags cfg_err next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_STE; i++) begin
        for (int r = 0; r < N_RANGE; r++) begin
          range_lo_r[i][r] <= {SYM_W{1'b1}};
          range_hi_r[i][r] <= {SYM_W{1'b0}};
        end
        edge_r[i] <= {N_STE{1'b0}};
      end
      report_r    <= {N_STE{1'b0}};
      start_all_r <= {N_STE{1'b0}};
      start_sod_r <= {N_STE{1'b0}};
      cfg_err_r   <= 1'b0;
    end else begin
      cfg_err_r <= cfg_we && !cfg_wr_s;
      for (int i = 0; i < N_STE; i++) begin
        if (cfg_wr_s && int'(cfg_ste) == i) begin
          for (int r = 0; r < N_RANGE; r++) begin
            if (int'(cfg_field) == r) begin
              range_lo_r[i][r] <= cfg_data[SYM_W-1:0];
              range_hi_r[i][r] <= cfg_data[16 +: SYM_W];
            end
          end
          if (int'(cfg_field) == N_RANGE) begin
            edge_r[i] <= cfg_data[N_STE-1:0];
          end
          if (int'(cfg_field) == N_RANGE + 1) begin
            report_r[i]    <= cfg_data[2];
            start_all_r[i] <= cfg_data[1];
            start_sod_r[i] <= cfg_data[0];
          end
        end
      end
    end
  end

  // Symbol match (lo > hi never matches) and successor enables
  always_comb begin
    match_s = {N_STE{1'b0}};
    succ_s  = {N_STE{1'b0}};
    for (int i = 0; i < N_STE; i++) begin
      for (int r = 0; r < N_RANGE; r++) begin
        match_s[i] = match_s[i] |
                     ((range_lo_r[i][r] <= symbols) && (symbols <= range_hi_r[i][r]));
      end
      succ_s = succ_s | (edge_r[i] & {N_STE{active_r[i]}});
    end
    next_active_s = (start_all_r | (start_sod_r & {N_STE{sod_r}}) | succ_s) & match_s;
  end

  // Active-state vector and start-of-data flag; flush wins over a symbol
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      active_r <= {N_STE{1'b0}};
      sod_r    <= 1'b1;
    end else if (accept_s) begin
      active_r <= next_active_s;
      sod_r    <= 1'b0;
    end
  end

  assign active     = active_r;
  assign report_vec = active_r & report_r;
  assign report     = |report_vec;
  assign cfg_err    = cfg_err_r;

`ifdef LTL_NFA_REPORT_CNT_EN
  logic [15:0]      report_cnt_r;
  logic [4:0]       first_idx_r;
  logic             first_vld_r;
  logic [N_STE-1:0] next_rep_s;

  function automatic logic [4:0] lowest_idx(input logic [N_STE-1:0] v);
    lowest_idx = 5'd0;
    for (int i = N_STE - 1; i >= 0; i--) begin
      lowest_idx = v[i] ? 5'(i) : lowest_idx;
    end
  endfunction

  assign next_rep_s = next_active_s & report_r;

  // Saturating report counter with first-report capture
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      report_cnt_r <= 16'd0;
      first_idx_r  <= 5'd0;
      first_vld_r  <= 1'b0;
    end else if (accept_s && (|next_rep_s)) begin
      if (report_cnt_r != 16'hFFFF) begin
        report_cnt_r <= report_cnt_r + 16'd1;
      end
      if (!first_vld_r) begin
        first_idx_r <= lowest_idx(next_rep_s);
        first_vld_r <= 1'b1;
      end
    end
  end

  assign report_cnt = report_cnt_r;
  assign first_idx  = first_idx_r;
  assign first_vld  = first_vld_r;
`else
  assign report_cnt = 16'd0;
  assign first_idx  = 5'd0;
  assign first_vld  = 1'b0;
`endif

endmodule

// File: tb/tb_ltl_nfa_engine.sv
// Directed self-checking bench for ltl_nfa_engine (default parameters).
module tb_ltl_nfa_engine;

  logic        clk = 1'b0;
  logic        reset, cfg_we, run, sym_valid, flush;
  logic [3:0]  cfg_ste, cfg_field;
  logic [31:0] cfg_data;
  logic [7:0]  symbols;
  logic        cfg_err, report, first_vld;
  logic [15:0] active, report_vec, report_cnt;
  logic [4:0]  first_idx;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  ltl_nfa_engine #(.SYM_W(8), .N_STE(16), .N_RANGE(4)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ste(cfg_ste),
    .cfg_field(cfg_field), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .run(run), .sym_valid(sym_valid), .symbols(symbols), .flush(flush),
    .active(active), .report_vec(report_vec), .report(report),
    .report_cnt(report_cnt), .first_idx(first_idx), .first_vld(first_vld)
  );

`ifdef LTL_NFA_REPORT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  task automatic cfg_wr(input logic [3:0] ste, input logic [3:0] fld, input logic [31:0] d);
    run = 1'b0; cfg_we = 1'b1; cfg_ste = ste; cfg_field = fld; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] s);
    run = 1'b1; sym_valid = 1'b1; symbols = s;
    tick();
    sym_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (active !== 16'h0000) begin failures++; $display("FAIL reset_active got=%h exp=0000", active); end
    checks++; if (report !== 1'b0) begin failures++; $display("FAIL reset_report got=%b exp=0", report); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
    checks++; if (report_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", report_cnt); end
    checks++; if (first_vld !== 1'b0 || first_idx !== 5'd0) begin failures++; $display("FAIL reset_first got=%b/%0d exp=0/0", first_vld, first_idx); end
  endtask

  task automatic test_sod();
    int pulses;
    do_reset();
    cfg_wr(4'd0, 4'd0, 32'h000F_0000);
    cfg_wr(4'd0, 4'd5, 32'h0000_0005);
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL sod_cfg_err got=%b exp=0", cfg_err); end
    send(8'h05);
    pulses = int'(report);
    checks++; if (active !== 16'h0001) begin failures++; $display("FAIL sod_first got=%h exp=0001", active); end
    send(8'h05);
    pulses += int'(report);
    checks++; if (active !== 16'h0000) begin failures++; $display("FAIL sod_second got=%h exp=0000", active); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL sod_pulses got=%0d exp=1", pulses); end
    checks++; if (report_cnt !== (CNT_EN ? 16'd1 : 16'd0)) begin failures++; $display("FAIL sod_cnt got=%0d exp=%0d", report_cnt, CNT_EN ? 1 : 0); end
  endtask

  task automatic test_chain();
    logic [7:0] syms [4] = '{8'h03, 8'h90, 8'hA0, 8'h10};
    logic       exp1 [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    cfg_wr(4'd0, 4'd0, 32'h000F_0000);
    cfg_wr(4'd0, 4'd5, 32'h0000_0001);
    cfg_wr(4'd0, 4'd4, 32'h0000_0002);
    cfg_wr(4'd1, 4'd0, 32'h00FF_0080);
    cfg_wr(4'd1, 4'd5, 32'h0000_0004);
    cfg_wr(4'd1, 4'd4, 32'h0000_0002);
    for (int k = 0; k < 4; k++) begin
      send(syms[k]);
      checks++; if (report_vec[1] !== exp1[k]) begin failures++; $display("FAIL chain_rv1[%0d] got=%b exp=%b", k, report_vec[1], exp1[k]); end
      if (k == 2) begin
        run = 1'b1; tick();
        checks++; if (active !== 16'h0002) begin failures++; $display("FAIL chain_hold got=%h exp=0002", active); end
      end
    end
    checks++; if (report_cnt !== (CNT_EN ? 16'd2 : 16'd0)) begin failures++; $display("FAIL chain_cnt got=%0d exp=%0d", report_cnt, CNT_EN ? 2 : 0); end
    checks++; if (first_idx !== (CNT_EN ? 5'd1 : 5'd0) || first_vld !== CNT_EN) begin failures++; $display("FAIL chain_first got=%b/%0d exp=%b/%0d", first_vld, first_idx, CNT_EN, CNT_EN ? 1 : 0); end
  endtask

  task automatic test_start_all();
    logic [7:0] syms [5] = '{8'h21, 8'h50, 8'h2F, 8'h30, 8'h20};
    logic       exp2 [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    cfg_wr(4'd2, 4'd0, 32'h002F_0020);
    cfg_wr(4'd2, 4'd5, 32'h0000_0002);
    for (int k = 0; k < 5; k++) begin
      send(syms[k]);
      checks++; if (active !== {13'd0, exp2[k], 2'b00}) begin failures++; $display("FAIL start_all[%0d] got=%h exp_bit2=%b", k, active, exp2[k]); end
    end
  endtask

  task automatic test_disabled_and_err();
    do_reset();
    cfg_wr(4'd3, 4'd0, 32'h0010_0040);
    cfg_wr(4'd3, 4'd5, 32'h0000_0002);
    send(8'h20);
    checks++; if (active !== 16'h0000) begin failures++; $display("FAIL disabled_0x20 got=%h exp=0000", active); end
    send(8'h40);
    checks++; if (active !== 16'h0000) begin failures++; $display("FAIL disabled_0x40 got=%h exp=0000", active); end
    run = 1'b1; cfg_we = 1'b1; cfg_ste = 4'd3; cfg_field = 4'd0; cfg_data = 32'h00FF_0000;
    tick();
    cfg_we = 1'b0;
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL err_run_pulse got=%b exp=1", cfg_err); end
    tick();
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL err_run_clear got=%b exp=0", cfg_err); end
    send(8'h20);
    checks++; if (active !== 16'h0000) begin failures++; $display("FAIL err_cfg_kept got=%h exp=0000", active); end
    cfg_wr(4'd3, 4'd6, 32'h00FF_0000);
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL err_field got=%b exp=1", cfg_err); end
    send(8'h20);
    checks++; if (active !== 16'h0000) begin failures++; $display("FAIL err_field_kept got=%h exp=0000", active); end
  endtask

  task automatic test_flush();
    do_reset();
    cfg_wr(4'd0, 4'd0, 32'h00FF_0000);
    cfg_wr(4'd0, 4'd5, 32'h0000_0005);
    cfg_wr(4'd0, 4'd4, 32'h0000_0001);
    cfg_wr(4'd1, 4'd0, 32'h0007_0007);
    cfg_wr(4'd1, 4'd5, 32'h0000_0002);
    send(8'h05);
    send(8'h06);
    checks++; if (active !== 16'h0001) begin failures++; $display("FAIL flush_pre got=%h exp=0001", active); end
    checks++; if (report_cnt !== (CNT_EN ? 16'd2 : 16'd0)) begin failures++; $display("FAIL flush_pre_cnt got=%0d exp=%0d", report_cnt, CNT_EN ? 2 : 0); end
    run = 1'b1; sym_valid = 1'b1; symbols = 8'h07; flush = 1'b1;
    tick();
    flush = 1'b0; sym_valid = 1'b0;
    checks++; if (active !== 16'h0000) begin failures++; $display("FAIL flush_active got=%h exp=0000", active); end
    checks++; if (report_cnt !== 16'd0 || first_vld !== 1'b0) begin failures++; $display("FAIL flush_cnt got=%0d/%b exp=0/0", report_cnt, first_vld); end
    send(8'h08);
    checks++; if (active !== 16'h0001) begin failures++; $display("FAIL flush_rearm got=%h exp=0001", active); end
    checks++; if (report_cnt !== (CNT_EN ? 16'd1 : 16'd0) || first_vld !== CNT_EN) begin failures++; $display("FAIL flush_post_cnt got=%0d/%b exp=%0d/%b", report_cnt, first_vld, CNT_EN ? 1 : 0, CNT_EN); end
  endtask

  task automatic test_reset_mid_trace();
    do_reset();
    cfg_wr(4'd0, 4'd0, 32'h00FF_0000);
    cfg_wr(4'd0, 4'd5, 32'h0000_0006);
    for (int k = 0; k < 5; k++) send(8'(k + 1));
    checks++; if (report_cnt !== (CNT_EN ? 16'd5 : 16'd0)) begin failures++; $display("FAIL mid_cnt5 got=%0d exp=%0d", report_cnt, CNT_EN ? 5 : 0); end
    checks++; if (active !== 16'h0001) begin failures++; $display("FAIL mid_active got=%h exp=0001", active); end
    reset = 1'b1; sym_valid = 1'b1; symbols = 8'h09;
    tick();
    reset = 1'b0; sym_valid = 1'b0;
    checks++; if (active !== 16'h0000) begin failures++; $display("FAIL mid_rst_active got=%h exp=0000", active); end
    checks++; if (report_cnt !== 16'd0 || first_vld !== 1'b0) begin failures++; $display("FAIL mid_rst_cnt got=%0d/%b exp=0/0", report_cnt, first_vld); end
    send(8'h10);
    checks++; if (active !== 16'h0000) begin failures++; $display("FAIL mid_rst_cfg got=%h exp=0000", active); end
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; run = 1'b0; sym_valid = 1'b0; flush = 1'b0;
    cfg_ste = 4'd0; cfg_field = 4'd0; cfg_data = 32'd0; symbols = 8'd0;
    test_reset();
    test_sod();
    test_chain();
    test_start_all();
    test_disabled_and_err();
    test_flush();
    test_reset_mid_trace();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
